// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and pointer helper shared by the reg FIFO and its read-side engine.
package fifo_pkg;

    localparam int FIFO_READER_BUF_DEPTH = 3;
    localparam int FIFO_READER_OCC_W     = $clog2(FIFO_READER_BUF_DEPTH + 1);
    localparam int FIFO_READER_PTR_W     = $clog2(FIFO_READER_BUF_DEPTH);

    // Advance a 0..depth-1 pointer, wrapping back to zero after the last slot.
    function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO read port plus downstream valid/ready stream seen by fifo_reader.
interface fifo_reader_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  fifoEmptyIn;
    logic                  fifoRdEnOut;
    logic [DATA_WIDTH-1:0] fifoRdDataIn;
    logic [DATA_WIDTH-1:0] outDataOut;
    logic                  outValidOut;
    logic                  outReadyIn;
    logic                  outLastOut;

    modport master (
        input  fifoEmptyIn, fifoRdDataIn, outReadyIn,
        output fifoRdEnOut, outDataOut, outValidOut, outLastOut
    );

    modport slave (
        output fifoEmptyIn, fifoRdDataIn, outReadyIn,
        input  fifoRdEnOut, outDataOut, outValidOut, outLastOut
    );

endinterface

// File: rtl/fifo_reader_buf.sv
// fifo_reader_buf: 3-entry circular skid buffer absorbing reads already in flight
// when downstream stalls.
module fifo_reader_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [DATA_WIDTH-1:0]        pushData_i,
    input  logic                         pop_i,
    output logic [DATA_WIDTH-1:0]        headData_o,
    output logic [FIFO_READER_OCC_W-1:0] occ_o
);

    localparam int PW = FIFO_READER_PTR_W;
    localparam int OW = FIFO_READER_OCC_W;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_READER_BUF_DEPTH];
    logic [PW-1:0]         headPtr_q, headPtr_d;
    logic [PW-1:0]         tailPtr_q, tailPtr_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic [DATA_WIDTH-1:0] lastData_q, lastData_d;

    always_comb begin
        headPtr_d  = headPtr_q;
        tailPtr_d  = tailPtr_q;
        occ_d      = occ_q;
        lastData_d = lastData_q;
        if (push_i) begin
            tailPtr_d = PW'(ptr_wrap(32'(tailPtr_q), FIFO_READER_BUF_DEPTH));
        end
        if (pop_i) begin
            headPtr_d  = PW'(ptr_wrap(32'(headPtr_q), FIFO_READER_BUF_DEPTH));
            lastData_d = mem_q[headPtr_q];
        end
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_READER_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            headPtr_q  <= '0;
            tailPtr_q  <= '0;
            occ_q      <= '0;
            lastData_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tailPtr_q] <= pushData_i;
            end
            headPtr_q  <= headPtr_d;
            tailPtr_q  <= tailPtr_d;
            occ_q      <= occ_d;
            lastData_q <= lastData_d;
        end
    end

    // When drained, the head slot holds stale data, so replay the last word popped instead.
    assign headData_o = (occ_q != '0) ? mem_q[headPtr_q] : lastData_q;
    assign occ_o      = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a registered-read FIFO into a valid/ready stream.
// Define FIFO_READER_LAST_EN to build the burst counter that drives outLastOut.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic          clkIn,
    input  logic          rstNIn,
    fifo_reader_if.master bus
);

    localparam int OW     = FIFO_READER_OCC_W;
    localparam int PEND_W = FIFO_READER_OCC_W + 1;

    logic              inFlight_q, inFlight_d;
    logic [OW-1:0]     occ;
    logic [PEND_W-1:0] pending;
    logic              rdEn;
    logic              outValid;
    logic              xfer;

    fifo_reader_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) uBuf (
        .clk       (clkIn),
        .rst_n     (rstNIn),
        .push_i    (inFlight_q),
        .pushData_i(bus.fifoRdDataIn),
        .pop_i     (xfer),
        .headData_o(bus.outDataOut),
        .occ_o     (occ)
    );

    // Count the in-flight word as occupied so the buffer can never overflow.
    assign pending    = PEND_W'(occ) + PEND_W'(inFlight_q);
    assign rdEn       = rstNIn && !bus.fifoEmptyIn && (pending < PEND_W'(FIFO_READER_BUF_DEPTH));
    assign inFlight_d = rdEn;

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            inFlight_q <= 1'b0;
        end else begin
            inFlight_q <= inFlight_d;
        end
    end

    assign outValid        = (occ != '0);
    assign xfer            = outValid && bus.outReadyIn;
    assign bus.fifoRdEnOut = rdEn;
    assign bus.outValidOut = outValid;

`ifdef FIFO_READER_LAST_EN
    localparam int CNT_W = $clog2(BURST_LEN);

    logic [CNT_W-1:0] burstCnt_q, burstCnt_d;

    always_comb begin
        burstCnt_d = burstCnt_q;
        if (xfer) begin
            burstCnt_d = (burstCnt_q == CNT_W'(BURST_LEN - 1)) ? '0 : burstCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            burstCnt_q <= '0;
        end else begin
            burstCnt_q <= burstCnt_d;
        end
    end

    assign bus.outLastOut = outValid && (burstCnt_q == CNT_W'(BURST_LEN - 1));
`else
    // Without last-marking BURST_LEN has no effect; the term below is constant zero.
    assign bus.outLastOut = (BURST_LEN < 2) & 1'b0;
`endif

endmodule
